// File: rtl/uart_hex_reader.sv
// Pops rx bytes, echoes them to tx, and assembles ASCII hex digits into a 32-bit word released on a terminator.
// Latency: rx_rden at t, echo at t+1, classify at t+2; stalls on a full tx FIFO and holds the word (no rx reads) until word_ready.
module uart_hex_reader #(
    parameter bit ECHO_EN = 1'b1,
    parameter int MAX_DIG = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_fifo_dvalid,
    input  logic [7:0]  rx_rdata,
    output logic        rx_rden,
    input  logic        tx_fifo_full,
    output logic [7:0]  tx_wdata,
    output logic        tx_wten,
    output logic [31:0] word_data,
    output logic [3:0]  word_ndig,
    output logic        word_ovf,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        char_err
);

    typedef enum logic [1:0] {IDLE, ECHO, EVAL, OUT} state_t;

    localparam logic [3:0] MAX_N = 4'(MAX_DIG);

    state_t      state;
    logic [7:0]  char_q;
    logic [31:0] acc;
    logic [3:0]  ndig;
    logic        ovf;

    logic        is_dig;
    logic        is_term;
    logic [3:0]  nib;

    always_comb begin
        is_dig = 1'b0;
        nib    = 4'h0;
        if (char_q >= 8'h30 && char_q <= 8'h39) begin
            is_dig = 1'b1;
            nib    = char_q[3:0];
        end else if ((char_q >= 8'h41 && char_q <= 8'h46) ||
                     (char_q >= 8'h61 && char_q <= 8'h66)) begin
            is_dig = 1'b1;
            nib    = char_q[3:0] + 4'd9;
        end
    end

    assign is_term = (char_q == 8'h0D) || (char_q == 8'h0A) || (char_q == 8'h20);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            char_q <= 8'h00;
            acc    <= 32'h0;
            ndig   <= 4'd0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_fifo_dvalid) begin
                        char_q <= rx_rdata;
                        state  <= ECHO;
                    end
                end
                ECHO: begin
                    if (!ECHO_EN || !tx_fifo_full)
                        state <= EVAL;
                end
                EVAL: begin
                    if (is_dig) begin
                        acc <= {acc[27:0], nib};
                        if (ndig == MAX_N)
                            ovf <= 1'b1;
                        else
                            ndig <= ndig + 4'd1;
                        state <= IDLE;
                    end else if (is_term) begin
                        // A bare terminator (e.g. LF after CR) emits nothing.
                        state <= (ndig != 4'd0) ? OUT : IDLE;
                    end else begin
                        acc   <= 32'h0;
                        ndig  <= 4'd0;
                        ovf   <= 1'b0;
                        state <= IDLE;
                    end
                end
                OUT: begin
                    if (word_ready) begin
                        acc   <= 32'h0;
                        ndig  <= 4'd0;
                        ovf   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode from state and are forced low while reset is asserted.
    assign rx_rden    = !rst && (state == IDLE) && rx_fifo_dvalid;
    assign tx_wten    = !rst && ECHO_EN && (state == ECHO) && !tx_fifo_full;
    assign tx_wdata   = tx_wten ? char_q : 8'h00;
    assign word_valid = !rst && (state == OUT);
    assign word_data  = word_valid ? acc  : 32'h0;
    assign word_ndig  = word_valid ? ndig : 4'd0;
    assign word_ovf   = word_valid ? ovf  : 1'b0;
    assign char_err   = !rst && (state == EVAL) && !is_dig && !is_term;

endmodule

// File: tb/tb_uart_hex_reader.sv
// Directed byte streams into a modelled rx FIFO; a scoreboard monitor checks echoes, words and error pulses.
module tb_uart_hex_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_fifo_dvalid;
    logic [7:0]  rx_rdata;
    logic        rx_rden;
    logic        tx_fifo_full;
    logic [7:0]  tx_wdata;
    logic        tx_wten;
    logic [31:0] word_data;
    logic [3:0]  word_ndig;
    logic        word_ovf;
    logic        word_valid;
    logic        word_ready;
    logic        char_err;

    uart_hex_reader #(.ECHO_EN(1'b1), .MAX_DIG(8)) dut (
        .clk(clk), .rst(rst),
        .rx_fifo_dvalid(rx_fifo_dvalid), .rx_rdata(rx_rdata), .rx_rden(rx_rden),
        .tx_fifo_full(tx_fifo_full), .tx_wdata(tx_wdata), .tx_wten(tx_wten),
        .word_data(word_data), .word_ndig(word_ndig), .word_ovf(word_ovf),
        .word_valid(word_valid), .word_ready(word_ready), .char_err(char_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  n;
        logic        o;
    } word_t;

    word_t      wordq[$];
    logic [7:0] pendq[$];
    logic [7:0] rxq[$];
    logic [7:0] echoq[$];
    logic [7:0] errq[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rd_cyc = 0;
    logic [7:0] last_rd = 8'h00;
    bit full_seen = 1'b0;
    bit wv_prev = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // rx FIFO model: head byte presented combinationally-equivalent, popped on rx_rden.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_rden && rxq.size() > 0)
            rxq.delete(0);
        while (pendq.size() > 0) begin
            rxq.push_back(pendq[0]);
            pendq.delete(0);
        end
        rx_fifo_dvalid <= (rxq.size() > 0);
        rx_rdata       <= (rxq.size() > 0) ? rxq[0] : 8'h00;
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            wv_prev   = 1'b0;
            full_seen = 1'b0;
        end else begin
            if (rx_rden) begin
                rd_cyc    = cyc;
                last_rd   = rx_rdata;
                full_seen = tx_fifo_full;
            end else if (tx_fifo_full) begin
                full_seen = 1'b1;
            end
            if (tx_wten) begin
                chk("tx_overrun", {31'b0, tx_fifo_full}, 32'd0);
                if (echoq.size() == 0) chk("echo_unexpected", 32'd1, 32'd0);
                else chk("echo_byte", {24'b0, tx_wdata}, {24'b0, echoq.pop_front()});
                if (!full_seen) chk("echo_latency", cyc - rd_cyc, 32'd1);
            end
            if (char_err) begin
                if (errq.size() == 0) chk("char_err_unexpected", 32'd1, 32'd0);
                else chk("char_err_byte", {24'b0, last_rd}, {24'b0, errq.pop_front()});
                if (!full_seen) chk("char_err_cycle", cyc - rd_cyc, 32'd2);
            end
            if (word_valid && !wv_prev && !full_seen)
                chk("word_latency", cyc - rd_cyc, 32'd3);
            if (word_valid && word_ready) begin
                if (wordq.size() == 0) begin
                    chk("word_unexpected", 32'd1, 32'd0);
                end else begin
                    word_t w;
                    w = wordq.pop_front();
                    chk("word_data", word_data, w.d);
                    chk("word_ndig", {28'b0, word_ndig}, {28'b0, w.n});
                    chk("word_ovf", {31'b0, word_ovf}, {31'b0, w.o});
                end
            end
            if (!word_valid && (word_data != 32'h0 || word_ndig != 4'd0 || word_ovf))
                chk("word_zero_when_idle", 32'd1, 32'd0);
            wv_prev = word_valid;
        end
    end

    task automatic send(input logic [7:0] b, input bit echo);
        pendq.push_back(b);
        if (echo) echoq.push_back(b);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b1);
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] n, input logic o);
        word_t w;
        w.d = d; w.n = n; w.o = o;
        wordq.push_back(w);
    endtask

    task automatic wait_idle(input string nm);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk);
            if (pendq.size() == 0 && rxq.size() == 0 && !rx_fifo_dvalid &&
                echoq.size() == 0 && wordq.size() == 0 && errq.size() == 0)
                done = 1'b1;
        end
        if (!done) chk({nm, "_drain_timeout"}, 32'd1, 32'd0);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string nm);
        @(negedge clk);
        chk({nm, "_rx_rden"}, {31'b0, rx_rden}, 32'd0);
        chk({nm, "_tx_wten"}, {31'b0, tx_wten}, 32'd0);
        chk({nm, "_tx_wdata"}, {24'b0, tx_wdata}, 32'd0);
        chk({nm, "_word_valid"}, {31'b0, word_valid}, 32'd0);
        chk({nm, "_word_data"}, word_data, 32'd0);
        chk({nm, "_word_ndig"}, {28'b0, word_ndig}, 32'd0);
        chk({nm, "_word_ovf"}, {31'b0, word_ovf}, 32'd0);
        chk({nm, "_char_err"}, {31'b0, char_err}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nrd, nwt;
        bit seen;
        rst = 1'b1; word_ready = 1'b1; tx_fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // "1A2b\r"
        expect_word(32'h00001A2B, 4'd4, 1'b0);
        send_str("1A2b"); send(8'h0D, 1'b1);
        wait_idle("t1");

        // Nine digits overflow, then a lone CR produces nothing
        expect_word(32'h23456789, 4'd8, 1'b1);
        send_str("123456789\n");
        wait_idle("t2");
        send(8'h0D, 1'b1);
        wait_idle("t2cr");

        // Illegal 'G' clears the partial word
        send_str("12");
        errq.push_back(8'h47);
        send_str("G3"); send(8'h0D, 1'b1);
        expect_word(32'h00000003, 4'd1, 1'b0);
        wait_idle("t3");

        // tx FIFO full for 100 cycles with 3 bytes waiting
        tx_fifo_full = 1'b1;
        send_str("9AB");
        nrd = 0; nwt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rx_rden) nrd++;
            if (tx_wten) nwt++;
        end
        chk("stall_reads", nrd, 32'd1);
        chk("stall_tx_wten", nwt, 32'd0);
        @(posedge clk); #1;
        tx_fifo_full = 1'b0;
        send(8'h0D, 1'b1);
        expect_word(32'h000009AB, 4'd3, 1'b0);
        wait_idle("t4");

        // Consumer backpressure holds the word and stops rx reads
        word_ready = 1'b0;
        expect_word(32'h000000FF, 4'd2, 1'b0);
        send_str("FF ");
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (word_valid) seen = 1'b1;
        end
        chk("bp_word_valid_seen", {31'b0, seen}, 32'd1);
        send_str("5"); send(8'h0D, 1'b1);
        expect_word(32'h00000005, 4'd1, 1'b0);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("bp_word_valid", {31'b0, word_valid}, 32'd1);
            chk("bp_word_data", word_data, 32'h000000FF);
            chk("bp_rx_rden", {31'b0, rx_rden}, 32'd0);
        end
        chk("bp_rx_pending", {31'b0, rx_fifo_dvalid}, 32'd1);
        @(posedge clk); #1;
        word_ready = 1'b1;
        @(posedge clk); #1;
        word_ready = 1'b0;
        @(negedge clk);
        chk("bp_release_valid", {31'b0, word_valid}, 32'd0);
        chk("bp_resume_read", {31'b0, rx_rden}, 32'd1);
        @(posedge clk); #1;
        word_ready = 1'b1;
        wait_idle("t5");

        // Reset mid-word while 'B' waits in ECHO
        send('h41, 1'b1);
        send('h42, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (tx_wten) seen = 1'b1;
        end
        chk("rst_first_echo_seen", {31'b0, seen}, 32'd1);
        @(posedge clk); #1;
        tx_fifo_full = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rx_rden) seen = 1'b1;
        end
        chk("rst_second_read_seen", {31'b0, seen}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        check_all_zero("midword_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        tx_fifo_full = 1'b0;
        expect_word(32'h00000007, 4'd1, 1'b0);
        send_str("7"); send(8'h0D, 1'b1);
        wait_idle("t6");

        chk("words_outstanding", wordq.size(), 32'd0);
        chk("echoes_outstanding", echoq.size(), 32'd0);
        chk("errors_outstanding", errq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_hex_reader.md
Name: uart_hex_reader

Overview:
- Consumer on the monitor side of the UART interface block's FIFO port. It reads received bytes one at a time from the rx FIFO with a single-cycle read strobe.
- Each byte is optionally echoed into the tx FIFO.
- ASCII hex digits are assembled into a 32-bit word. A terminator character releases the word to the monitor command logic through a valid/ready handshake.

Parameters:
- ECHO_EN, 1, 1 = echo every accepted character to the tx FIFO; 0 = never assert tx_wten.
- MAX_DIG, 8, digit count at which word_ndig saturates (one 32-bit word); legal range 1..8.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rx_fifo_dvalid  in  1  rx FIFO holds at least one byte
- rx_rdata  in  8  rx FIFO head byte; valid in the same cycle as rx_fifo_dvalid (asynchronous RAM read)
- rx_rden  out  1  rx FIFO pop strobe, one cycle
- tx_fifo_full  in  1  tx FIFO holds 8 bytes
- tx_wdata  out  8  echo byte
- tx_wten  out  1  tx FIFO push strobe, one cycle
- word_data  out  32  assembled hex value, right-aligned
- word_ndig  out  4  number of digits in word_data, 1..MAX_DIG
- word_ovf  out  1  more than MAX_DIG digits were received; only the low 32 bits are kept
- word_valid  out  1  word available; held until word_ready
- word_ready  in  1  consumer accepts the word
- char_err  out  1  one-cycle pulse on an illegal character

Behaviour:
- Reset values: all outputs 0, state IDLE, accumulator 0, digit count 0, ovf 0. rst=1 in any state aborts immediately; a partially assembled word and any captured character are discarded.
- FSM states: IDLE, ECHO, EVAL, OUT.
- IDLE:
  - rx_rden = rx_fifo_dvalid (combinational, asserted only in IDLE).
  - On that edge, capture char_q <= rx_rdata and go to ECHO.
  - rx_rden is never asserted while rx_fifo_dvalid=0, so rx FIFO underrun cannot occur.
  - Reads are at most one per 3 cycles.
- ECHO:
  - If ECHO_EN=0, go to EVAL.
  - If ECHO_EN=1 and tx_fifo_full=0: tx_wten=1 and tx_wdata=char_q for one cycle, then go to EVAL.
  - If tx_fifo_full=1: stay in ECHO with tx_wten=0. No character is dropped; no tx overrun.
  - The echo is the unmodified received byte, including terminators and illegal characters.
- EVAL classifies char_q:
  - Digit: 0x30-0x39 gives value 0-9; 0x41-0x46 and 0x61-0x66 give 10-15.
    - acc <= {acc[27:0], nibble}.
    - ndig <= ndig+1, saturating at MAX_DIG.
    - If ndig was already MAX_DIG, set ovf.
    - Go to IDLE.
  - Terminator (0x0D CR, 0x0A LF, 0x20 space):
    - If ndig>0, go to OUT.
    - If ndig=0, go to IDLE with no output, so CR+LF pairs produce one word only.
  - Any other byte: char_err=1 for one cycle; clear acc, ndig and ovf; go to IDLE.
- OUT:
  - word_valid=1; word_data=acc, word_ndig=ndig, word_ovf=ovf, all stable while word_valid=1.
  - Transfer completes on a cycle with word_valid=1 and word_ready=1. Next cycle: word_valid=0, acc/ndig/ovf cleared, state IDLE.
  - No rx reads occur while in OUT. Backpressure from the consumer is therefore passed on to the rx FIFO.
  - word_ready asserted outside OUT is ignored.
- word_data/word_ndig/word_ovf are 0 whenever word_valid=0.
- Latency, first byte with ECHO_EN=1 and tx not full:
  - rx_rden at cycle t, tx_wten at t+1, EVAL at t+2.
  - Digit: accumulator updated and visible at t+3.
  - Terminator: word_valid=1 from t+3.

Test Plan:
- Byte stream "1A2b\r" (0x31,0x41,0x32,0x62,0x0D) with word_ready=1 -> tx_wten echoes exactly those 5 bytes in order; one word_valid with word_data=0x00001A2B, word_ndig=4, word_ovf=0; char_err never asserted.
- "123456789\n" -> word_data=0x23456789, word_ndig=8, word_ovf=1. Then "\r" alone -> no word_valid.
- "12G3\r" -> char_err pulse exactly in the EVAL cycle for 'G' (0x47); resulting word_data=0x00000003, word_ndig=1.
- tx_fifo_full held high 100 cycles while 3 bytes wait in the rx FIFO -> tx_wten=0 throughout and rx_rden stays low after the first read. After release, all 3 bytes are echoed in order and none are lost.
- "FF " then word_ready low 50 cycles with rx_fifo_dvalid=1 -> word_valid held with word_data=0x000000FF stable and rx_rden=0. word_ready=1 for one cycle -> word_valid=0 next cycle and reading resumes.
- rst=1 for one cycle after "AB" (mid-word, state ECHO) -> all outputs 0. The following "7\r" yields word_data=0x00000007, word_ndig=1.
